// File: rtl/fu_stream_issuer.sv
// Operand feeder for fixed-latency, non-stallable function pipelines: operand FIFO,
// credit-gated issue, valid-tag delay line and first-word-fall-through result FIFO.
module fu_stream_issuer #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned PIPE_LAT = 20,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             start,
   input  logic [CNT_W-1:0] job_len,
   output logic             busy,
   output logic             done,
   output logic [31:0]      fu_data,
   input  logic [31:0]      fu_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   state_t            state_q;
   logic [CNT_W-1:0]  remaining_q;
   logic [PIPE_LAT:0] tag_q;

   logic [31:0]       op_mem [DEPTH];
   logic [ADDR_W-1:0] op_wr_q, op_rd_q;
   logic [ADDR_W:0]   op_cnt_q, op_cnt_d;

   logic [31:0]       res_mem [DEPTH];
   logic [ADDR_W-1:0] res_wr_q, res_rd_q;
   logic [ADDR_W:0]   res_cnt_q, res_cnt_d;

   logic [ADDR_W:0]   inflight_q, inflight_d;

   logic op_push, issue, capture, res_pop, credit_ok;

   assign in_ready  = !reset && (op_cnt_q != FULL_CNT);
   assign op_push   = in_valid && in_ready;
   // Results already queued plus those still in the pipe must fit; pops this cycle are not credited.
   assign credit_ok = ({1'b0, res_cnt_q} + {1'b0, inflight_q}) < {1'b0, FULL_CNT};
   assign issue     = (state_q == S_RUN) && (op_cnt_q != '0) && credit_ok;
   // Tag reaches index PIPE_LAT on the edge where the delayed operand is on fu_result.
   assign capture   = tag_q[PIPE_LAT];
   assign out_valid = (res_cnt_q != '0);
   assign res_pop   = out_valid && out_ready;
   assign out_data  = out_valid ? res_mem[res_rd_q] : '0;

   always_comb begin
      op_cnt_d   = op_cnt_q;
      res_cnt_d  = res_cnt_q;
      inflight_d = inflight_q;
      if (op_push && !issue)      op_cnt_d = op_cnt_q + 1'b1;
      else if (!op_push && issue) op_cnt_d = op_cnt_q - 1'b1;
      if (capture && !res_pop)      res_cnt_d = res_cnt_q + 1'b1;
      else if (!capture && res_pop) res_cnt_d = res_cnt_q - 1'b1;
      if (issue && !capture)      inflight_d = inflight_q + 1'b1;
      else if (!issue && capture) inflight_d = inflight_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (op_push) op_mem[op_wr_q]   <= in_data;
      if (capture) res_mem[res_wr_q] <= fu_result;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         tag_q       <= '0;
         op_wr_q     <= '0;
         op_rd_q     <= '0;
         op_cnt_q    <= '0;
         res_wr_q    <= '0;
         res_rd_q    <= '0;
         res_cnt_q   <= '0;
         inflight_q  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fu_data     <= '0;
      end else begin
         done       <= 1'b0;
         fu_data    <= issue ? op_mem[op_rd_q] : '0;
         tag_q      <= {tag_q[PIPE_LAT-1:0], issue};
         op_cnt_q   <= op_cnt_d;
         res_cnt_q  <= res_cnt_d;
         inflight_q <= inflight_d;
         if (op_push) op_wr_q  <= op_wr_q + 1'b1;
         if (issue)   op_rd_q  <= op_rd_q + 1'b1;
         if (capture) res_wr_q <= res_wr_q + 1'b1;
         if (res_pop) res_rd_q <= res_rd_q + 1'b1;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  remaining_q <= job_len;
                  busy        <= 1'b1;
                  if (job_len == '0) begin
                     state_q <= S_DONE;
                     done    <= 1'b1;
                  end else begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (issue) begin
                  remaining_q <= remaining_q - CNT_W'(1);
                  if (remaining_q == CNT_W'(1)) state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (inflight_q == '0 && !capture) begin
                  state_q <= S_DONE;
                  done    <= 1'b1;
               end
            end
            S_DONE: begin
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fu_stream_issuer.sv
// Directed bench for fu_stream_issuer; the function unit is modelled as a
// PIPE_LAT-register delay of fu_data.
module tb_fu_stream_issuer;

   localparam int unsigned DEPTH    = 16;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned PIPE_LAT = 20;
   localparam int unsigned CNT_W    = 8;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             start;
   logic [CNT_W-1:0] job_len;
   logic             busy;
   logic             done;
   logic [31:0]      fu_data;
   logic [31:0]      fu_result;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;

   fu_stream_issuer #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .PIPE_LAT (PIPE_LAT),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .start     (start),
      .job_len   (job_len),
      .busy      (busy),
      .done      (done),
      .fu_data   (fu_data),
      .fu_result (fu_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   logic [31:0] fu_pipe [PIPE_LAT];
   always @(posedge clk) begin
      fu_pipe[0] <= fu_data;
      for (int i = 1; i < int'(PIPE_LAT); i++) fu_pipe[i] <= fu_pipe[i-1];
   end
   assign fu_result = fu_pipe[PIPE_LAT-1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] A = 32'h4100_0000;
   localparam logic [31:0] B = 32'h3FC0_0000;
   localparam logic [31:0] C = 32'h4080_0000;

   int  s, r, n, m, dcyc, bad, pushed;
   logic p;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; start = 1'b0;
      job_len = '0; out_ready = 1'b0;
      for (int i = 0; i < int'(PIPE_LAT); i++) fu_pipe[i] = '0;

      // Reset state
      tick; tick;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_fu_data", fu_data, 32'd0);
      reset = 1'b0;
      tick;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Single job
      in_valid = 1'b1; in_data = 32'h4000_0000;
      tick;
      in_valid = 1'b0;
      start = 1'b1; job_len = 8'd1;
      tick;
      start = 1'b0;
      s = cyc;
      chk("single_busy", {31'd0, busy}, 32'd1);
      chk("single_fu_pre", fu_data, 32'd0);
      tick;
      chk("single_fu_issue", fu_data, 32'h4000_0000);
      tick;
      chk("single_fu_post", fu_data, 32'd0);
      for (int t = 0; t < 60 && !out_valid; t++) tick;
      chk("single_latency", 32'(cyc - s), 32'(PIPE_LAT + 2));
      chk("single_data", out_data, 32'h4000_0000);
      chk("single_done_early", {31'd0, done}, 32'd0);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("single_done", {31'd0, done}, 32'd1);
      chk("single_popped", {31'd0, out_valid}, 32'd0);
      tick;
      chk("single_done_fall", {31'd0, done}, 32'd0);
      chk("single_busy_fall", {31'd0, busy}, 32'd0);

      // Streaming
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 32'h3F80_0000 + 32'(i);
         tick;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      start = 1'b1; job_len = 8'd8;
      tick;
      start = 1'b0;
      s = cyc;
      for (int k = 0; k < 8; k++) begin
         tick;
         chk("stream_issue", fu_data, 32'h3F80_0000 + 32'(k));
      end
      tick;
      chk("stream_issue_end", fu_data, 32'd0);
      n = 0; dcyc = 0;
      for (int t = 0; t < 60 && dcyc == 0; t++) begin
         tick;
         if (out_valid) begin
            chk("stream_data", out_data, 32'h3F80_0000 + 32'(n));
            chk("stream_cycle", 32'(cyc), 32'(s + 22 + n));
            n++;
         end
         if (done) dcyc = cyc;
      end
      chk("stream_count", 32'(n), 32'd8);
      chk("stream_done_cycle", 32'(dcyc), 32'(s + 30));
      tick;
      chk("stream_busy_fall", {31'd0, busy}, 32'd0);

      // Credit stall
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = A + 32'(i);
         tick;
      end
      in_valid = 1'b0;
      chk("stall_op_full", {31'd0, in_ready}, 32'd0);
      start = 1'b1; job_len = 8'd20;
      tick;
      start = 1'b0;
      s = cyc;
      in_valid = 1'b1; in_data = A + 32'd16; pushed = 0;
      for (int k = 0; k < 16; k++) begin
         p = in_valid && in_ready;
         tick;
         if (p) begin
            pushed++;
            if (pushed == 4) in_valid = 1'b0;
            else in_data = A + 32'(16 + pushed);
         end
         chk("stall_issue", fu_data, A + 32'(k));
      end
      chk("stall_pushed", 32'(pushed), 32'd4);
      bad = 0;
      while (cyc < s + 45) begin
         tick;
         if (fu_data != '0) bad++;
      end
      chk("stall_no_issue", 32'(bad), 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_head", out_data, A);
      r = cyc;
      out_ready = 1'b1;
      n = 0; m = 0; dcyc = 0;
      for (int t = 0; t < 80 && dcyc == 0; t++) begin
         if (out_valid) begin
            chk("stall_result", out_data, A + 32'(n));
            n++;
         end
         if (fu_data != '0) begin
            chk("stall_late_issue", fu_data, A + 32'(16 + m));
            chk("stall_late_cycle", 32'(cyc), 32'(r + 2 + m));
            m++;
         end
         if (done) dcyc = cyc;
         if (dcyc == 0) tick;
      end
      chk("stall_results", 32'(n), 32'd20);
      chk("stall_late_count", 32'(m), 32'd4);
      chk("stall_done_cycle", 32'(dcyc), 32'(r + 27));
      tick;

      // Zero length, plus a start on the DONE->IDLE edge
      start = 1'b1; job_len = 8'd0;
      tick;
      job_len = 8'd5;
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_busy", {31'd0, busy}, 32'd1);
      tick;
      start = 1'b0;
      chk("zero_done_fall", {31'd0, done}, 32'd0);
      chk("zero_late_start_ignored", {31'd0, busy}, 32'd0);
      tick;
      chk("zero_no_issue", fu_data, 32'd0);
      chk("zero_idle", {31'd0, busy}, 32'd0);

      // Starvation with an ignored start in RUN
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = B;
      tick;
      in_valid = 1'b0;
      start = 1'b1; job_len = 8'd3;
      tick;
      job_len = 8'd1;
      tick;
      start = 1'b0;
      chk("starve_first", fu_data, B);
      bad = 0;
      for (int t = 0; t < 10; t++) begin
         tick;
         if (fu_data != '0 || !busy || done) bad++;
      end
      chk("starve_wait", 32'(bad), 32'd0);
      in_valid = 1'b1; in_data = B + 32'd1;
      tick;
      in_data = B + 32'd2;
      tick;
      in_valid = 1'b0;
      chk("starve_issue1", fu_data, B + 32'd1);
      tick;
      chk("starve_issue2", fu_data, B + 32'd2);
      n = 0; dcyc = 0;
      for (int t = 0; t < 60 && dcyc == 0; t++) begin
         tick;
         if (out_valid) begin
            chk("starve_result", out_data, B + 32'(n));
            n++;
         end
         if (done) dcyc = cyc;
      end
      chk("starve_count", 32'(n), 32'd3);
      chk("starve_done_seen", {31'd0, dcyc != 0}, 32'd1);
      tick;
      chk("starve_busy_fall", {31'd0, busy}, 32'd0);

      // Reset mid-job with 5 in flight and 3 results queued
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = C + 32'(i);
         tick;
      end
      in_valid = 1'b0;
      start = 1'b1; job_len = 8'd8;
      tick;
      start = 1'b0;
      s = cyc;
      while (cyc < s + 24) tick;
      chk("midrst_queued", {31'd0, out_valid}, 32'd1);
      chk("midrst_head", out_data, C);
      reset = 1'b1;
      tick;
      chk("midrst_in_ready_low", {31'd0, in_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      bad = 0;
      for (int t = 0; t < int'(PIPE_LAT) + 5; t++) begin
         tick;
         if (out_valid || done || busy || fu_data != '0) bad++;
      end
      chk("midrst_quiet", 32'(bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
